// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// load/store funct3 encodings and the legal RAM latency range.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int RAM_LATENCY_MIN = 1;
  localparam int RAM_LATENCY_MAX = 7;

  function automatic bit ram_latency_ok(input int n);
    return (n >= RAM_LATENCY_MIN) && (n <= RAM_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a RAM word,
// and merges sub-word store data into a RAM word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    case (lane)
      2'd0:    sel_b = word[7:0];
      2'd1:    sel_b = word[15:8];
      2'd2:    sel_b = word[23:16];
      default: sel_b = word[31:24];
    endcase
    sel_h = lane[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{sel_b[7]}}, sel_b};
      F3_H:    load_data = {{16{sel_h[15]}}, sel_h};
      F3_BU:   load_data = {24'h0, sel_b};
      F3_HU:   load_data = {16'h0, sel_h};
      F3_W:    load_data = word;
      default: load_data = word;
    endcase

    // Only the addressed lane(s) change; the rest of the word is written back as read.
    store_data = word;
    case (funct3[1:0])
      2'b00: begin
        case (lane)
          2'd0:    store_data[7:0]   = wdata[7:0];
          2'd1:    store_data[15:8]  = wdata[7:0];
          2'd2:    store_data[23:16] = wdata[7:0];
          default: store_data[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) store_data[31:16] = wdata;
        else         store_data[15:0]  = wdata;
      end
      default: store_data = word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit on a single word-wide RAM port without byte enables.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them.
module lsu
  import lsu_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        fault_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  // state    | meaning
  // ST_IDLE  | waiting for start_i
  // ST_READ  | RAM read in flight, RAM_LATENCY cycles
  // ST_WRITE | we_o asserted for one cycle
  // ST_DONE  | done_o pulse, then back to idle

  if (!ram_latency_ok(RAM_LATENCY)) begin : g_bad_latency
    $error("lsu: RAM_LATENCY must be in 1..7");
  end

  localparam logic [2:0] CNT_INIT = 3'(RAM_LATENCY - 1);

  lsu_state_e  state;
  logic [2:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        store_q;

  logic        legal;
  logic        fault_req;
  logic [31:0] addr_eff;
  logic [31:0] load_data;
  logic [31:0] store_data;

  always_comb begin
    legal = is_store_i ? (funct3_i inside {F3_B, F3_H, F3_W})
                       : (funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    addr_eff = addr_i;
`ifdef LSU_MISALIGN_TRAP_EN
    fault_req = !legal
              || (funct3_i[1:0] == 2'b01 && addr_i[0])
              || (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
`else
    fault_req = !legal;
    if (funct3_i[1:0] == 2'b01)      addr_eff[0]   = 1'b0;
    else if (funct3_i[1:0] == 2'b10) addr_eff[1:0] = 2'b00;
`endif
  end

  lsu_align u_align (
    .funct3     (f3_q),
    .lane       (lane_q),
    .word       (data_i),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= 3'd0;
      f3_q    <= 3'd0;
      lane_q  <= 2'd0;
      wdata_q <= 16'h0;
      store_q <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      rdata_o <= 32'h0;
      fault_o <= 1'b0;
      we_o    <= 1'b0;
      addr_o  <= 32'h0;
      data_o  <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            f3_q    <= funct3_i;
            lane_q  <= addr_eff[1:0];
            wdata_q <= wdata_i[15:0];
            store_q <= is_store_i;
            cnt     <= CNT_INIT;
            busy_o  <= 1'b1;
            rdata_o <= 32'h0;
            if (fault_req) begin
              state   <= ST_DONE;
              done_o  <= 1'b1;
              fault_o <= 1'b1;
            end else if (is_store_i && funct3_i == F3_W) begin
              state  <= ST_WRITE;
              we_o   <= 1'b1;
              addr_o <= {addr_eff[31:2], 2'b00};
              data_o <= wdata_i;
            end else begin
              state  <= ST_READ;
              addr_o <= {addr_eff[31:2], 2'b00};
            end
          end
        end
        ST_READ: begin
          if (cnt == 3'd0) begin
            if (store_q) begin
              state  <= ST_WRITE;
              we_o   <= 1'b1;
              data_o <= store_data;
            end else begin
              state   <= ST_DONE;
              done_o  <= 1'b1;
              rdata_o <= load_data;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_WRITE: begin
          we_o   <= 1'b0;
          done_o <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          done_o  <= 1'b0;
          fault_o <= 1'b0;
          busy_o  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: two instances (RAM_LATENCY 1 and 2) on private RAM models.
module tb_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        sel = 1'b0;

  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = 8'h0;
  logic [31:0] pre_val = 32'h0;

  logic        start1, start2;
  logic        busy1, done1, fault1, we1, busy2, done2, fault2, we2;
  logic [31:0] rdata1, addr_o1, data_o1, data_i1, rdata2, addr_o2, data_o2, data_i2;
  logic [31:0] mem1 [0:255];
  logic [31:0] mem2 [0:255];
  int          we_tot1 = 0, we_tot2 = 0;

  assign start1 = start & ~sel;
  assign start2 = start & sel;
  assign data_i1 = mem1[addr_o1[9:2]];
  assign data_i2 = mem2[addr_o2[9:2]];

  always @(posedge clk) begin
    if (pre_en) mem1[pre_idx] <= pre_val;
    else if (we1) begin
      mem1[addr_o1[9:2]] <= data_o1;
      we_tot1 <= we_tot1 + 1;
    end
  end

  always @(posedge clk) begin
    if (pre_en) mem2[pre_idx] <= pre_val;
    else if (we2) begin
      mem2[addr_o2[9:2]] <= data_o2;
      we_tot2 <= we_tot2 + 1;
    end
  end

  lsu #(.RAM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start_i(start1), .is_store_i(is_store), .funct3_i(funct3),
    .addr_i(addr), .wdata_i(wdata), .busy_o(busy1), .done_o(done1), .rdata_o(rdata1),
    .fault_o(fault1), .we_o(we1), .addr_o(addr_o1), .data_i(data_i1), .data_o(data_o1)
  );

  lsu #(.RAM_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .start_i(start2), .is_store_i(is_store), .funct3_i(funct3),
    .addr_i(addr), .wdata_i(wdata), .busy_o(busy2), .done_o(done2), .rdata_o(rdata2),
    .fault_o(fault2), .we_o(we2), .addr_o(addr_o2), .data_i(data_i2), .data_o(data_o2)
  );

  logic        o_busy, o_done, o_fault, o_we;
  logic [31:0] o_rdata, o_addr, o_data;
  assign o_busy  = sel ? busy2  : busy1;
  assign o_done  = sel ? done2  : done1;
  assign o_fault = sel ? fault2 : fault1;
  assign o_we    = sel ? we2    : we1;
  assign o_rdata = sel ? rdata2 : rdata1;
  assign o_addr  = sel ? addr_o2 : addr_o1;
  assign o_data  = sel ? data_o2 : data_o1;

  int n_checks = 0;
  int n_fail = 0;

  int          r_done_cyc, r_we_cyc, r_we_cnt;
  logic        r_fault, r_busy_ok, r_idle_after;
  logic [31:0] r_rdata, r_wdata, r_waddr, r_addr1;

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    pre_en = 1'b1; pre_idx = a[9:2]; pre_val = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Issues one request from a negedge and records when done_o/we_o appear (cycle 1 = first after accept).
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit poke);
    r_done_cyc = -1; r_we_cyc = -1; r_we_cnt = 0; r_busy_ok = 1'b1;
    r_fault = 1'bx; r_rdata = 'x; r_wdata = 'x; r_waddr = 'x; r_addr1 = 'x;
    is_store = st; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (poke) begin
        is_store = 1'b1; funct3 = F3_W; addr = 32'h104; wdata = 32'hBADBAD00;
      end else start = 1'b0;
      if (k == 1) r_addr1 = o_addr;
      if (!o_busy) r_busy_ok = 1'b0;
      if (o_we) begin
        r_we_cnt++; r_we_cyc = k; r_wdata = o_data; r_waddr = o_addr;
      end
      if (o_done) begin
        r_done_cyc = k; r_rdata = o_rdata; r_fault = o_fault;
        break;
      end
    end
    start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
    @(negedge clk);
    r_idle_after = !o_busy;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy1, done1, fault1, we1, rdata1, addr_o1, data_o1} !== 100'h0) begin
      n_fail++; $display("FAIL reset_outputs_n1: got %h expected 0", {busy1, done1, fault1, we1, rdata1, addr_o1, data_o1});
    end
    n_checks++;
    if ({busy2, done2, fault2, we2, rdata2, addr_o2, data_o2} !== 100'h0) begin
      n_fail++; $display("FAIL reset_outputs_n2: got %h expected 0", {busy2, done2, fault2, we2, rdata2, addr_o2, data_o2});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw;
    preload(32'h100, 32'hDEADBEEF);
    sel = 1'b0;
    do_op(1'b0, F3_W, 32'h100, 32'h0, 1'b0);
    n_checks++; if (r_done_cyc !== 2) begin n_fail++; $display("FAIL lw_n1_done_cycle: got %0d expected 2", r_done_cyc); end
    n_checks++; if (r_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_n1_rdata: got %h expected deadbeef", r_rdata); end
    n_checks++; if (r_fault !== 1'b0) begin n_fail++; $display("FAIL lw_n1_fault: got %b expected 0", r_fault); end
    n_checks++; if (r_addr1 !== 32'h100) begin n_fail++; $display("FAIL lw_n1_addr: got %h expected 00000100", r_addr1); end
    n_checks++; if (r_we_cnt !== 0) begin n_fail++; $display("FAIL lw_n1_we_count: got %0d expected 0", r_we_cnt); end
    n_checks++; if (!(r_busy_ok && r_idle_after)) begin n_fail++; $display("FAIL lw_n1_busy: got %b%b expected 11", r_busy_ok, r_idle_after); end
    n_checks++; if (rdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_n1_rdata_hold: got %h expected deadbeef", rdata1); end
    sel = 1'b1;
    do_op(1'b0, F3_W, 32'h100, 32'h0, 1'b0);
    n_checks++; if (r_done_cyc !== 3) begin n_fail++; $display("FAIL lw_n2_done_cycle: got %0d expected 3", r_done_cyc); end
    n_checks++; if (r_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_n2_rdata: got %h expected deadbeef", r_rdata); end
  endtask

  task automatic test_subword_load;
    preload(32'h100, 32'h80FF1234);
    sel = 1'b0;
    do_op(1'b0, F3_B, 32'h103, 32'h0, 1'b0);
    n_checks++; if (r_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_103: got %h expected ffffff80", r_rdata); end
    do_op(1'b0, F3_BU, 32'h103, 32'h0, 1'b0);
    n_checks++; if (r_rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu_103: got %h expected 00000080", r_rdata); end
    do_op(1'b0, F3_HU, 32'h102, 32'h0, 1'b0);
    n_checks++; if (r_rdata !== 32'h000080FF) begin n_fail++; $display("FAIL lhu_102: got %h expected 000080ff", r_rdata); end
    do_op(1'b0, F3_H, 32'h102, 32'h0, 1'b0);
    n_checks++; if (r_rdata !== 32'hFFFF80FF) begin n_fail++; $display("FAIL lh_102: got %h expected ffff80ff", r_rdata); end
    do_op(1'b0, F3_H, 32'h100, 32'h0, 1'b0);
    n_checks++; if (r_rdata !== 32'h00001234) begin n_fail++; $display("FAIL lh_100: got %h expected 00001234", r_rdata); end
    do_op(1'b0, F3_B, 32'h101, 32'h0, 1'b0);
    n_checks++; if (r_rdata !== 32'h00000012) begin n_fail++; $display("FAIL lb_101: got %h expected 00000012", r_rdata); end
  endtask

  task automatic test_misalign;
    preload(32'h100, 32'h12348001);
    sel = 1'b0;
    do_op(1'b0, F3_H, 32'h101, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++; if (r_done_cyc !== 1) begin n_fail++; $display("FAIL lh_101_trap_cycle: got %0d expected 1", r_done_cyc); end
    n_checks++; if (r_fault !== 1'b1) begin n_fail++; $display("FAIL lh_101_trap_fault: got %b expected 1", r_fault); end
    n_checks++; if (r_rdata !== 32'h0) begin n_fail++; $display("FAIL lh_101_trap_rdata: got %h expected 0", r_rdata); end
`else
    n_checks++; if (r_done_cyc !== 2) begin n_fail++; $display("FAIL lh_101_align_cycle: got %0d expected 2", r_done_cyc); end
    n_checks++; if (r_addr1 !== 32'h100) begin n_fail++; $display("FAIL lh_101_align_addr: got %h expected 00000100", r_addr1); end
    n_checks++; if (r_rdata !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_101_align_rdata: got %h expected ffff8001", r_rdata); end
    n_checks++; if (r_fault !== 1'b0) begin n_fail++; $display("FAIL lh_101_align_fault: got %b expected 0", r_fault); end
`endif
    do_op(1'b0, F3_W, 32'h102, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++; if (r_fault !== 1'b1 || r_done_cyc !== 1) begin n_fail++; $display("FAIL lw_102_trap: got fault %b cycle %0d expected 1 1", r_fault, r_done_cyc); end
`else
    n_checks++; if (r_rdata !== 32'h12348001) begin n_fail++; $display("FAIL lw_102_align: got %h expected 12348001", r_rdata); end
`endif
  endtask

  task automatic test_stores;
    preload(32'h100, 32'h11223344);
    sel = 1'b1;
    do_op(1'b1, F3_B, 32'h101, 32'hFFFFFFAB, 1'b0);
    n_checks++; if (r_we_cnt !== 1) begin n_fail++; $display("FAIL sb_n2_we_count: got %0d expected 1", r_we_cnt); end
    n_checks++; if (r_we_cyc !== 3) begin n_fail++; $display("FAIL sb_n2_we_cycle: got %0d expected 3", r_we_cyc); end
    n_checks++; if (r_wdata !== 32'h1122AB44) begin n_fail++; $display("FAIL sb_n2_data: got %h expected 1122ab44", r_wdata); end
    n_checks++; if (r_waddr !== 32'h100) begin n_fail++; $display("FAIL sb_n2_addr: got %h expected 00000100", r_waddr); end
    n_checks++; if (r_done_cyc !== 4) begin n_fail++; $display("FAIL sb_n2_done_cycle: got %0d expected 4", r_done_cyc); end
    n_checks++; if (mem2[8'h40] !== 32'h1122AB44) begin n_fail++; $display("FAIL sb_n2_mem: got %h expected 1122ab44", mem2[8'h40]); end
    preload(32'h104, 32'hAAAABBBB);
    preload(32'h10C, 32'h11223344);
    sel = 1'b0;
    do_op(1'b1, F3_H, 32'h106, 32'h12345678, 1'b0);
    n_checks++; if (r_we_cyc !== 2 || r_done_cyc !== 3) begin n_fail++; $display("FAIL sh_n1_timing: got we %0d done %0d expected 2 3", r_we_cyc, r_done_cyc); end
    n_checks++; if (mem1[8'h41] !== 32'h5678BBBB) begin n_fail++; $display("FAIL sh_n1_mem: got %h expected 5678bbbb", mem1[8'h41]); end
    do_op(1'b1, F3_B, 32'h10F, 32'h000000EE, 1'b0);
    n_checks++; if (mem1[8'h43] !== 32'hEE223344) begin n_fail++; $display("FAIL sb_lane3_mem: got %h expected ee223344", mem1[8'h43]); end
    do_op(1'b1, F3_W, 32'h108, 32'hCAFEF00D, 1'b0);
    n_checks++; if (r_we_cyc !== 1 || r_done_cyc !== 2 || r_we_cnt !== 1) begin n_fail++; $display("FAIL sw_n1_timing: got we %0d done %0d count %0d expected 1 2 1", r_we_cyc, r_done_cyc, r_we_cnt); end
    n_checks++; if (r_waddr !== 32'h108 || mem1[8'h42] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL sw_n1_write: got addr %h mem %h expected 00000108 cafef00d", r_waddr, mem1[8'h42]); end
  endtask

  task automatic test_fault;
    sel = 1'b0;
    do_op(1'b1, 3'b100, 32'h100, 32'h55, 1'b0);
    n_checks++; if (r_done_cyc !== 1 || r_fault !== 1'b1) begin n_fail++; $display("FAIL store_f3_100: got cycle %0d fault %b expected 1 1", r_done_cyc, r_fault); end
    n_checks++; if (r_we_cnt !== 0 || r_rdata !== 32'h0) begin n_fail++; $display("FAIL store_f3_100_side: got we %0d rdata %h expected 0 0", r_we_cnt, r_rdata); end
    do_op(1'b0, 3'b011, 32'h100, 32'h0, 1'b0);
    n_checks++; if (r_done_cyc !== 1 || r_fault !== 1'b1) begin n_fail++; $display("FAIL load_f3_011: got cycle %0d fault %b expected 1 1", r_done_cyc, r_fault); end
    n_checks++; if (fault1 !== 1'b0) begin n_fail++; $display("FAIL fault_pulse: got %b expected 0", fault1); end
  endtask

  task automatic test_back_to_back;
    int wt;
    preload(32'h100, 32'h80FF1234);
    preload(32'h104, 32'h55555555);
    sel = 1'b1;
    wt = we_tot2;
    do_op(1'b0, F3_W, 32'h100, 32'h0, 1'b1);
    n_checks++; if (r_rdata !== 32'h80FF1234 || r_done_cyc !== 3) begin n_fail++; $display("FAIL busy_start_result: got %h cycle %0d expected 80ff1234 3", r_rdata, r_done_cyc); end
    repeat (3) @(negedge clk);
    n_checks++; if (busy2 !== 1'b0 || we_tot2 !== wt) begin n_fail++; $display("FAIL busy_start_ignored: got busy %b writes %0d expected 0 %0d", busy2, we_tot2, wt); end
    n_checks++; if (mem2[8'h41] !== 32'h55555555) begin n_fail++; $display("FAIL busy_start_mem: got %h expected 55555555", mem2[8'h41]); end
  endtask

  task automatic test_reset_abort;
    int wt;
    preload(32'h100, 32'h11223344);
    sel = 1'b1;
    wt = we_tot2;
    is_store = 1'b1; funct3 = F3_B; addr = 32'h101; wdata = 32'hAB; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL abort_in_read: got busy %b expected 1", busy2); end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy2, done2, fault2, we2, rdata2, addr_o2, data_o2} !== 100'h0) begin
      n_fail++; $display("FAIL abort_outputs: got %h expected 0", {busy2, done2, fault2, we2, rdata2, addr_o2, data_o2});
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (we_tot2 !== wt || mem2[8'h40] !== 32'h11223344) begin n_fail++; $display("FAIL abort_no_write: got writes %0d mem %h expected %0d 11223344", we_tot2, mem2[8'h40], wt); end
    n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy %b expected 0", busy2); end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_subword_load;
    test_misalign;
    test_stores;
    test_fault;
    test_back_to_back;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
